// File: rtl/move_cmd_arbiter_pkg.sv
// rtl/move_cmd_arbiter_pkg.sv - shared command bit indices and hold-time default
package keyboardPkg;

    localparam int CMD_W     = 5;
    localparam int CMD_LEFT  = 0;
    localparam int CMD_RIGHT = 1;
    localparam int CMD_JUMP  = 2;
    localparam int CMD_UP    = 3;
    localparam int CMD_DOWN  = 4;

    localparam int                CNT_W               = 21;
    localparam logic [CNT_W-1:0]  HOLD_CYCLES_DEFAULT = 21'd1_000_000;

    typedef logic [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/move_cmd_arbiter_if.sv
// rtl/move_cmd_arbiter_if.sv - keyboard and remote command request/ack bundle
interface move_cmd_arbiter_if;
    import keyboardPkg::*;

    cmd_t kb_cmd;
    logic kb_valid;
    logic kb_ack;
    cmd_t rm_cmd;
    logic rm_valid;
    logic rm_ack;

    // requesters drive commands and consume acks
    modport master (
        output kb_cmd, kb_valid, rm_cmd, rm_valid,
        input  kb_ack, rm_ack
    );

    // arbiter samples commands and returns acks
    modport slave (
        input  kb_cmd, kb_valid, rm_cmd, rm_valid,
        output kb_ack, rm_ack
    );
endinterface

// File: rtl/cmd_prio_enc.sv
// rtl/cmd_prio_enc.sv - reduces a multi-bit command to one bit, jump>up>down>left>right
module cmd_prio_enc
    import keyboardPkg::*;
(
    input  cmd_t cmd_i,
    output cmd_t onehot_o
);

    // fixed priority pick of the single movement to perform
    always_comb begin
        onehot_o = '0;
        if (cmd_i[CMD_JUMP])       onehot_o[CMD_JUMP]  = 1'b1;
        else if (cmd_i[CMD_UP])    onehot_o[CMD_UP]    = 1'b1;
        else if (cmd_i[CMD_DOWN])  onehot_o[CMD_DOWN]  = 1'b1;
        else if (cmd_i[CMD_LEFT])  onehot_o[CMD_LEFT]  = 1'b1;
        else if (cmd_i[CMD_RIGHT]) onehot_o[CMD_RIGHT] = 1'b1;
    end

endmodule

// File: rtl/move_cmd_arbiter.sv
// rtl/move_cmd_arbiter.sv - round-robin arbiter of keyboard/remote move commands with game FSM
module move_cmd_arbiter
    import keyboardPkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    move_cmd_arbiter_if.slave   req_if,
    input  logic                start_req_i,
    input  logic                hit_i,
    input  logic                win_i,
    output logic                left_o,
    output logic                right_o,
    output logic                jump_o,
    output logic                up_o,
    output logic                down_o,
    output logic                start_game_o,
    output logic                game_over_o,
    output logic                owner_o
);

    typedef enum logic [1:0] {ST_WAIT, ST_PLAY, ST_HOLD, ST_OVER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cmd_t               cmd_q, cmd_d;
    logic               kb_ack_q, kb_ack_d;
    logic               rm_ack_q, rm_ack_d;
    logic               start_game_q, start_game_d;
    logic               game_over_q, game_over_d;
    logic               owner_q, owner_d;
    logic               seen_low_q, seen_low_d;

    cmd_t kb_onehot, rm_onehot, grant_cmd;
    logic end_game, grant_kb, grant_rm, hold_done;

    cmd_prio_enc u_kb_enc (.cmd_i(req_if.kb_cmd), .onehot_o(kb_onehot));
    cmd_prio_enc u_rm_enc (.cmd_i(req_if.rm_cmd), .onehot_o(rm_onehot));

    // owner==1 means remote went last, so keyboard wins a tie and vice versa
    assign end_game  = hit_i | win_i;
    assign grant_kb  = req_if.kb_valid & (~req_if.rm_valid | owner_q);
    assign grant_rm  = req_if.rm_valid & (~req_if.kb_valid | ~owner_q);
    assign grant_cmd = grant_kb ? kb_onehot : rm_onehot;
    assign hold_done = (cnt_q == HOLD_CYCLES - 21'd1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    // next-state decision; hit/win outranks any grant while the game runs
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (start_req_i) state_d = ST_PLAY;
            ST_PLAY: begin
                if (end_game)                                   state_d = ST_OVER;
                else if ((grant_kb | grant_rm) && grant_cmd != '0) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (end_game)       state_d = ST_OVER;
                else if (hold_done) state_d = ST_PLAY;
            end
            ST_OVER: if (start_req_i && seen_low_q) state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // next values of the registered outputs, acks, owner and hold counter
    always_comb begin
        cmd_d        = '0;
        kb_ack_d     = 1'b0;
        rm_ack_d     = 1'b0;
        owner_d      = owner_q;
        cnt_d        = '0;
        seen_low_d   = 1'b0;
        start_game_d = (state_d == ST_PLAY) || (state_d == ST_HOLD);
        game_over_d  = (state_d == ST_OVER);
        case (state_q)
            ST_PLAY: begin
                if (!end_game && (grant_kb | grant_rm)) begin
                    kb_ack_d = grant_kb;
                    rm_ack_d = grant_rm;
                    owner_d  = grant_rm;
                    cmd_d    = grant_cmd;
                end
            end
            ST_HOLD: begin
                if (state_d == ST_HOLD) begin
                    cmd_d = cmd_q;
                    cnt_d = cnt_q + 21'd1;
                end
            end
            ST_OVER: seen_low_d = seen_low_q | ~start_req_i;
            default: ;
        endcase
    end

    // output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            kb_ack_q     <= 1'b0;
            rm_ack_q     <= 1'b0;
            start_game_q <= 1'b0;
            game_over_q  <= 1'b0;
            owner_q      <= 1'b1;
            cnt_q        <= '0;
            seen_low_q   <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            kb_ack_q     <= kb_ack_d;
            rm_ack_q     <= rm_ack_d;
            start_game_q <= start_game_d;
            game_over_q  <= game_over_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            seen_low_q   <= seen_low_d;
        end
    end

    assign req_if.kb_ack = kb_ack_q;
    assign req_if.rm_ack = rm_ack_q;
    assign left_o        = cmd_q[CMD_LEFT];
    assign right_o       = cmd_q[CMD_RIGHT];
    assign jump_o        = cmd_q[CMD_JUMP];
    assign up_o          = cmd_q[CMD_UP];
    assign down_o        = cmd_q[CMD_DOWN];
    assign start_game_o  = start_game_q;
    assign game_over_o   = game_over_q;
    assign owner_o       = owner_q;

endmodule

// File: doc/move_cmd_arbiter.md
MOVE_CMD_ARBITER -- requirements
Module: move_cmd_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 21'd1_000_000, number of cycles a granted command is held on the outputs (legal range 1..2^21-1).
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 kb_cmd  input  5  local keyboard command {down,up,jump,right,left}; kb_valid  input  1  kb_cmd qualifier.
REQ-005 rm_cmd  input  5  remote (UART) command, same bit order; rm_valid  input  1  rm_cmd qualifier.
REQ-006 kb_ack, rm_ack  output  1 each  one-cycle grant/consume pulse to the respective requester.
REQ-007 start_req  input  1  start button level; hit  input  1  collision with barrel/Kong; win  input  1  goal reached.
REQ-008 left, right, jump, up, down  output  1 each  one-hot command to the movement block.
REQ-009 start_game  output  1  game running; game_over  output  1  game ended; owner  output  1  last granted source (0 = kb, 1 = rm).

Function
REQ-010 All outputs SHALL be registered; FSM states ST_WAIT, ST_PLAY, ST_HOLD, ST_OVER.
REQ-011 ST_WAIT: command outputs 0, start_game 0, no acks; start_req=1 -> ST_PLAY next cycle.
REQ-012 ST_PLAY: start_game 1; if exactly one of kb_valid/rm_valid is 1, that source is granted.
REQ-013 If both are valid in ST_PLAY, the source not equal to owner is granted (round-robin); owner updates to the granted source.
REQ-014 Grant in cycle N: ack for that source = 1 in cycle N+1 only; loser gets no ack and must keep its request.
REQ-015 Multi-bit command reduced to one bit with priority jump > up > down > left > right.
REQ-016 Nonzero granted command: from N+1, the selected output = 1 for exactly HOLD_CYCLES cycles (ST_HOLD), then 0 and back to ST_PLAY.
REQ-017 Zero granted command: ack still issued, no output asserted, FSM stays ST_PLAY.
REQ-018 Requests arriving during ST_HOLD SHALL be ignored (not acked) until return to ST_PLAY.
REQ-019 Hold counter 21 bits, counts 0..HOLD_CYCLES-1, cleared on every grant and on entry to ST_PLAY; never wraps.
REQ-020 hit or win = 1 in ST_PLAY or ST_HOLD -> ST_OVER next cycle; command outputs forced 0 in that same next cycle; any pending grant in that cycle dropped (hit/win has priority over grant).
REQ-021 ST_OVER: game_over 1, start_game 0, no acks; start_req=1 -> ST_WAIT, but only after start_req has been seen 0 at least once in ST_OVER (edge requirement).
REQ-022 hit/win in ST_WAIT or ST_OVER SHALL be ignored.

Reset
REQ-023 On rst: state ST_WAIT, all command outputs 0, acks 0, start_game 0, game_over 0, owner 1 (so kb wins first tie), counter 0.
REQ-024 rst during ST_HOLD terminates the hold; outputs 0 in the cycle after rst is sampled.

Structure
REQ-025 Command bit indices (CMD_LEFT=0..CMD_DOWN=4) and HOLD_CYCLES default SHALL live in keyboardPkg; the state typedef stays local.
REQ-026 One sub-module cmd_prio_enc (5-bit priority encoder to one-hot, combinational) SHALL be instantiated per source.

Verification (HOLD_CYCLES=4)
REQ-027 Reset, kb_valid=1 cmd=5'b00001 while in ST_WAIT -> no ack, left=0; start_req pulse -> start_game=1 next cycle.
REQ-028 ST_PLAY, kb_cmd=5'b00100 valid at N -> kb_ack=1 at N+1, jump=1 at N+1..N+4, 0 at N+5.
REQ-029 Both valid (kb=00010, rm=01000) for 12 cycles from reset owner=1 -> kb granted first (right x4), then rm (up x4), owner 0 then 1.
REQ-030 kb_cmd=5'b11111 -> only jump asserted; kb_cmd=5'b00000 valid -> kb_ack pulse, no output, next request granted the following cycle.
REQ-031 hit=1 at hold cycle 2 -> outputs 0 and game_over=1 next cycle; start_req held 1 -> stays ST_OVER; drop then raise -> ST_WAIT.
REQ-032 rst asserted mid-hold -> all outputs at reset values the next cycle.
